packet_merge: RTL and testbench

PACKET_MERGE -- requirements
Module: packet_merge

---
 rtl/noc_pkg.sv | 24 ++
 rtl/pkt_fifo.sv | 65 ++++++
 rtl/packet_merge.sv | 112 +++++++++++
 tb/tb_packet_merge.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared packet-network definitions: packet width, packet type, output-stage
// state encoding and the round-robin grant helper.
package noc_pkg;

  localparam int unsigned WIDTH_PACKAGE = 33;

  typedef logic [WIDTH_PACKAGE-1:0] packet_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // Pick the input to serve: alternate away from last_grant when both are
  // pending, otherwise take whichever one is pending.
  function automatic logic rr_pick(input logic ne0, input logic ne1,
                                   input logic last_grant);
    if (ne0 && ne1) begin
      return ~last_grant;
    end
    return ne1;
  endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Per-input packet FIFO. The caller only pushes when count < DEPTH and only
// pops when count > 0; simultaneous push and pop keeps count unchanged.
module pkt_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Next-state for storage, pointers (natural power-of-two wrap) and count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Packet storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/packet_merge.sv
// Two-input packet merger: each input is buffered in its own FIFO, a
// round-robin arbiter feeds a single registered output stage.
module packet_merge #(
  parameter int unsigned WIDTH_PACKAGE = noc_pkg::WIDTH_PACKAGE,
  parameter int unsigned DEPTH         = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH_PACKAGE-1:0] in0_data,
  input  logic                     in0_valid,
  output logic                     in0_ready,
  input  logic [WIDTH_PACKAGE-1:0] in1_data,
  input  logic                     in1_valid,
  output logic                     in1_ready,
  output logic [WIDTH_PACKAGE-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_src
);

  import noc_pkg::*;

  localparam int unsigned   CW         = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [CW-1:0]            count0, count1;
  logic [WIDTH_PACKAGE-1:0] dout0, dout1;
  logic                     push0, push1, pop0, pop1;
  logic                     ne0, ne1, load, grant;

  out_state_t               state_q, state_d;
  logic [WIDTH_PACKAGE-1:0] out_data_q, out_data_d;
  logic                     out_src_q, out_src_d;
  logic                     last_grant_q, last_grant_d;

  // Ready comes from the registered count only: a pop on this edge does not
  // free a slot for a push on the same edge.
  assign in0_ready = !rst && (count0 < FULL_COUNT);
  assign in1_ready = !rst && (count1 < FULL_COUNT);
  assign push0     = in0_valid && in0_ready;
  assign push1     = in1_valid && in1_ready;

  pkt_fifo #(
    .WIDTH (WIDTH_PACKAGE),
    .DEPTH (DEPTH)
  ) u_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .push  (push0),
    .pop   (pop0),
    .din   (in0_data),
    .dout  (dout0),
    .count (count0)
  );

  pkt_fifo #(
    .WIDTH (WIDTH_PACKAGE),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push1),
    .pop   (pop1),
    .din   (in1_data),
    .dout  (dout1),
    .count (count1)
  );

  // Arbitration and output-stage next state: load whenever the stage is
  // empty or being drained and some FIFO has data.
  always_comb begin
    ne0          = (count0 != '0);
    ne1          = (count1 != '0);
    grant        = rr_pick(ne0, ne1, last_grant_q);
    load         = ((state_q == OUT_EMPTY) || out_ready) && (ne0 || ne1);
    pop0         = load && !grant;
    pop1         = load && grant;
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;
    if (load) begin
      state_d      = OUT_FULL;
      out_data_d   = grant ? dout1 : dout0;
      out_src_d    = grant;
      last_grant_d = grant;
    end else if (out_ready) begin
      state_d = OUT_EMPTY;
    end
  end

  // Output register and arbiter history; last_grant resets to 1 so port 0
  // wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= OUT_EMPTY;
      out_data_q   <= '0;
      out_src_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = (state_q == OUT_FULL);
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_packet_merge.sv
// Scoreboard bench for packet_merge: a queue-based reference model predicts
// every output-stage load; a separate monitor compares what the DUT presents.
module tb_packet_merge;

  localparam int unsigned W     = 33;
  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic         src;
    logic [W-1:0] data;
  } beat_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] in0_data, in1_data, out_data;
  logic         in0_valid, in0_ready, in1_valid, in1_ready;
  logic         out_valid, out_ready, out_src;

  packet_merge #(
    .WIDTH_PACKAGE (W),
    .DEPTH         (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_data  (in0_data),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in1_data  (in1_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src)
  );

  int    vectors     = 0;
  int    miscompares = 0;

  // Model: packets accepted but not yet in the output stage, per input.
  logic [W-1:0] fq0[$];
  logic [W-1:0] fq1[$];
  // Expected output-stage contents in load order; observed transfers.
  beat_t        exp_q[$];
  beat_t        obs_q[$];
  bit           m_last = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: mid-cycle compare of readies and output stage against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("in0_ready_in_rst", 64'(in0_ready), 64'd0);
        chk("in1_ready_in_rst", 64'(in1_ready), 64'd0);
      end else begin
        chk("in0_ready", 64'(in0_ready), 64'(fq0.size() < DEPTH));
        chk("in1_ready", 64'(in1_ready), 64'(fq1.size() < DEPTH));
        chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0 && out_valid) begin
          chk("out_data", 64'(out_data), 64'(exp_q[0].data));
          chk("out_src", 64'(out_src), 64'(exp_q[0].src));
        end
        if (out_valid && out_ready) obs_q.push_back(beat_t'{src: out_src, data: out_data});
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Reference model: decides, for the coming edge, acceptance and which
  // pending packet (if any) enters the output stage.
  initial begin : model
    bit           r0, r1, g;
    logic [W-1:0] d;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        fq0.delete();
        fq1.delete();
        exp_q.delete();
        m_last = 1'b1;
      end else begin
        r0 = fq0.size() < DEPTH;
        r1 = fq1.size() < DEPTH;
        if (exp_q.size() == 0 && (fq0.size() != 0 || fq1.size() != 0)) begin
          if (fq0.size() != 0 && fq1.size() != 0) g = !m_last;
          else                                    g = (fq0.size() == 0);
          d = g ? fq1.pop_front() : fq0.pop_front();
          exp_q.push_back(beat_t'{src: g, data: d});
          m_last = g;
        end
        if (in0_valid && r0) fq0.push_back(in0_data);
        if (in1_valid && r1) fq1.push_back(in1_data);
      end
    end
  end

  // One cycle of stimulus; entered and left 1 time unit after a rising edge.
  task automatic step(input bit v0, input logic [W-1:0] d0, input bit v1,
                      input logic [W-1:0] d1, input bit ordy,
                      output bit f0, output bit f1);
    in0_valid = v0;
    in0_data  = d0;
    in1_valid = v1;
    in1_data  = d1;
    out_ready = ordy;
    #3;
    f0 = v0 && in0_ready;
    f1 = v1 && in1_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit ordy);
    bit f0, f1;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, ordy, f0, f1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1, 1'b1);
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "timeout");
  end

  initial begin : driver
    bit           f0, f1;
    int           acc, i0, i1, s0, s1;
    logic [W-1:0] b0 [3];
    logic [W-1:0] b1 [3];
    logic [W-1:0] bseq [6];

    rst = 1'b1;
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
    in0_data = '0; in1_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #3;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", 64'(out_data), 64'd0);
    chk("reset_out_src", 64'(out_src), 64'd0);
    @(posedge clk);
    #1;

    // Single packet latency.
    step(1'b1, 33'h0_0000_00AA, 1'b0, '0, 1'b1, f0, f1);
    chk("lat_accept", 64'(f0), 64'd1);
    in0_valid = 1'b0;
    #3;
    chk("lat_not_yet", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    #3;
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_data", 64'(out_data), 64'hAA);
    chk("lat_src", 64'(out_src), 64'd0);
    @(posedge clk);
    #1;
    idle(3, 1'b1);

    // Two contending streams alternate, port 0 first.
    do_reset();
    obs_q.delete();
    b0 = '{33'h1, 33'h2, 33'h3};
    b1 = '{33'h101, 33'h102, 33'h103};
    bseq = '{33'h1, 33'h101, 33'h2, 33'h102, 33'h3, 33'h103};
    i0 = 0; i1 = 0;
    for (int c = 0; c < 20 && (i0 < 3 || i1 < 3); c++) begin
      step(i0 < 3, b0[i0 < 3 ? i0 : 0], i1 < 3, b1[i1 < 3 ? i1 : 0], 1'b1, f0, f1);
      if (f0) i0++;
      if (f1) i1++;
    end
    chk("rr_sent", 64'(i0 + i1), 64'd6);
    idle(6, 1'b1);
    chk("rr_count", 64'(obs_q.size()), 64'd6);
    for (int k = 0; k < 6 && k < obs_q.size(); k++) begin
      chk("rr_seq_data", 64'(obs_q[k].data), 64'(bseq[k]));
      chk("rr_seq_src", 64'(obs_q[k].src), 64'(k % 2));
    end

    // Back-pressure: one packet in the output stage plus DEPTH in the FIFO.
    do_reset();
    obs_q.delete();
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      step(acc < 4, 33'h100 + 33'(acc), 1'b0, '0, 1'b0, f0, f1);
      if (f0) acc++;
    end
    chk("bp_accepted", 64'(acc), 64'd3);
    chk("bp_in0_ready", 64'(in0_ready), 64'd0);
    chk("bp_held_data", 64'(out_data), 64'h100);
    for (int c = 0; c < 10 && acc < 4; c++) begin
      step(1'b1, 33'h100 + 33'(acc), 1'b0, '0, 1'b1, f0, f1);
      if (f0) acc++;
    end
    idle(6, 1'b1);
    chk("bp_count", 64'(obs_q.size()), 64'd4);
    for (int k = 0; k < 4 && k < obs_q.size(); k++)
      chk("bp_order", 64'(obs_q[k].data), 64'h100 + 64'(k));

    // Simultaneous push and pop with one entry buffered.
    do_reset();
    obs_q.delete();
    step(1'b1, 33'h200, 1'b0, '0, 1'b0, f0, f1);
    step(1'b1, 33'h201, 1'b0, '0, 1'b0, f0, f1);
    step(1'b1, 33'h202, 1'b0, '0, 1'b1, f0, f1);
    chk("pp_accept", 64'(f0), 64'd1);
    chk("pp_ready_after", 64'(in0_ready), 64'd1);
    step(1'b1, 33'h203, 1'b0, '0, 1'b0, f0, f1);
    chk("pp_ready_full", 64'(in0_ready), 64'd0);
    idle(6, 1'b1);
    chk("pp_count", 64'(obs_q.size()), 64'd4);
    for (int k = 0; k < 4 && k < obs_q.size(); k++)
      chk("pp_order", 64'(obs_q[k].data), 64'h200 + 64'(k));

    // Reset while everything is full discards all held packets.
    do_reset();
    obs_q.delete();
    for (int c = 0; c < 6; c++)
      step(1'b1, 33'h1_DEAD_0000 + 33'(c), 1'b1, 33'h1_BEEF_0000 + 33'(c), 1'b0, f0, f1);
    chk("mr_full_rdy0", 64'(in0_ready), 64'd0);
    chk("mr_full_rdy1", 64'(in1_ready), 64'd0);
    chk("mr_full_valid", 64'(out_valid), 64'd1);
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    do_reset();
    #3;
    chk("mr_out_valid", 64'(out_valid), 64'd0);
    chk("mr_rdy0", 64'(in0_ready), 64'd1);
    chk("mr_rdy1", 64'(in1_ready), 64'd1);
    @(posedge clk);
    #1;
    idle(6, 1'b1);
    chk("mr_no_leak", 64'(obs_q.size()), 64'd0);

    // Random valid/ready traffic, 1000 packets per input.
    obs_q.delete();
    s0 = 0; s1 = 0;
    for (int cyc = 0; cyc < 20000 && (s0 < 1000 || s1 < 1000); cyc++) begin
      step(s0 < 1000 && ($urandom_range(99) < 60), {1'($urandom), 32'($urandom)},
           s1 < 1000 && ($urandom_range(99) < 60), {1'($urandom), 32'($urandom)},
           $urandom_range(99) < 70, f0, f1);
      if (f0) s0++;
      if (f1) s1++;
    end
    chk("rnd_sent0", 64'(s0), 64'd1000);
    chk("rnd_sent1", 64'(s1), 64'd1000);
    idle(10, 1'b1);
    chk("rnd_delivered", 64'(obs_q.size()), 64'd2000);
    chk("rnd_drained", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
